// File: rtl/countdown_timer_if.sv
// Command/status bundle between a controller and the hh:mm:ss countdown timer.
// The controller (master) issues load/start/pause and reads back the remaining
// time; the timer (slave) consumes the commands and drives the registered status.
interface countdown_timer_if;
    logic       io_load;
    logic [4:0] io_load_hrs;
    logic [5:0] io_load_min;
    logic [5:0] io_load_sec;
    logic       io_start;
    logic       io_pause;
    logic [4:0] io_count_hrs;
    logic [5:0] io_count_min;
    logic [5:0] io_count_sec;
    logic       io_running;
    logic       io_done;

    modport master (
        output io_load,
        output io_load_hrs,
        output io_load_min,
        output io_load_sec,
        output io_start,
        output io_pause,
        input  io_count_hrs,
        input  io_count_min,
        input  io_count_sec,
        input  io_running,
        input  io_done
    );

    modport slave (
        input  io_load,
        input  io_load_hrs,
        input  io_load_min,
        input  io_load_sec,
        input  io_start,
        input  io_pause,
        output io_count_hrs,
        output io_count_min,
        output io_count_sec,
        output io_running,
        output io_done
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable hh:mm:ss countdown timer. A duration is loaded while stopped, then
// counted down once per second (TICKS_PER_SEC clock cycles) while running.
// Reaching 00:00:00 parks the block in DONE and emits a one-cycle io_done pulse.
// Every output comes straight from a register.
module countdown_timer #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int PRESC_W       = 26
) (
    input  logic              clock,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Prescaler value on which the one-second tick fires and the prescaler wraps.
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state_reg, state_next;
    logic [4:0]         hrs_reg, hrs_next;
    logic [5:0]         min_reg, min_next;
    logic [5:0]         sec_reg, sec_next;
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic               running_reg, running_next;
    logic               done_reg, done_next;

    // Load values limited to a legal time of day.
    logic [4:0]         load_hrs;
    logic [5:0]         load_min;
    logic [5:0]         load_sec;

    // Remaining time after one one-second decrement of the current count.
    logic [4:0]         dec_hrs;
    logic [5:0]         dec_min;
    logic [5:0]         dec_sec;

    logic               count_zero;
    logic               dec_zero;
    logic               tick;

    // Clamp the requested duration so the counters never exceed 23:59:59.
    always_comb begin
        load_hrs = (bus.io_load_hrs > 5'd23) ? 5'd23 : bus.io_load_hrs;
        load_min = (bus.io_load_min > 6'd59) ? 6'd59 : bus.io_load_min;
        load_sec = (bus.io_load_sec > 6'd59) ? 6'd59 : bus.io_load_sec;
    end

    // Borrow chain sec -> min -> hrs; an all-zero count stays at zero (no wrap).
    always_comb begin
        dec_hrs = hrs_reg;
        dec_min = min_reg;
        dec_sec = sec_reg;
        if (sec_reg != 6'd0) begin
            dec_sec = sec_reg - 6'd1;
        end else if (min_reg != 6'd0) begin
            dec_min = min_reg - 6'd1;
            dec_sec = 6'd59;
        end else if (hrs_reg != 5'd0) begin
            dec_hrs = hrs_reg - 5'd1;
            dec_min = 6'd59;
            dec_sec = 6'd59;
        end
    end

    assign count_zero = (hrs_reg == 5'd0) && (min_reg == 6'd0) && (sec_reg == 6'd0);
    assign dec_zero   = (dec_hrs == 5'd0) && (dec_min == 6'd0) && (dec_sec == 6'd0);

    // The second boundary only exists while counting.
    assign tick = (state_reg == RUN) && (presc_reg == PRESC_LAST);

    // Next-state and next-output logic; commands are prioritised load > start > pause.
    always_comb begin
        state_next = state_reg;
        hrs_next   = hrs_reg;
        min_next   = min_reg;
        sec_next   = sec_reg;
        presc_next = presc_reg;
        done_next  = 1'b0;

        case (state_reg)
            RUN: begin
                // Load and start have no effect while counting.
                if (tick) begin
                    presc_next = '0;
                    hrs_next   = dec_hrs;
                    min_next   = dec_min;
                    sec_next   = dec_sec;
                    // Expiry takes precedence over a pause issued on the same cycle.
                    if (dec_zero) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (bus.io_pause) begin
                        state_next = PAUSE;
                    end
                end else if (bus.io_pause) begin
                    // Sub-second phase is discarded; resume restarts a full second.
                    state_next = PAUSE;
                    presc_next = '0;
                end else begin
                    presc_next = presc_reg + PRESC_W'(1);
                end
            end

            default: begin
                // IDLE, PAUSE and DONE all accept load and start; pause is meaningless here.
                if (bus.io_load) begin
                    hrs_next   = load_hrs;
                    min_next   = load_min;
                    sec_next   = load_sec;
                    presc_next = '0;
                    state_next = IDLE;
                end else if (bus.io_start && !count_zero) begin
                    presc_next = '0;
                    state_next = RUN;
                end
            end
        endcase

        running_next = (state_next == RUN);
    end

    // State, counters, prescaler and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            hrs_reg     <= 5'd0;
            min_reg     <= 6'd0;
            sec_reg     <= 6'd0;
            presc_reg   <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hrs_reg     <= hrs_next;
            min_reg     <= min_next;
            sec_reg     <= sec_next;
            presc_reg   <= presc_next;
            running_reg <= running_next;
            done_reg    <= done_next;
        end
    end

    assign bus.io_count_hrs = hrs_reg;
    assign bus.io_count_min = min_reg;
    assign bus.io_count_sec = sec_reg;
    assign bus.io_running   = running_reg;
    assign bus.io_done      = done_reg;

endmodule
